data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory with a fixed, programmable access latency,
//   answering a pipeline MEM stage through a req/ack handshake.
//
//   Parameters
//     DEPTH    number of 32-bit words
//     LATENCY  wait cycles per access (0..15)
//
//   Ports
//     clk_i    clock, rising edge
//     rst_i    synchronous reset, active low (clears state and all memory)
//     req_i    access request, held by the initiator until ack_o
//     we_i     1 = write, 0 = read
//     addr_i   byte address (must be word aligned and inside DEPTH)
//     wdata_i  write data
//     ack_o    one-cycle completion pulse
//     rdata_o  read data, valid with ack_o on reads, held between acks
//     err_o    access error, only ever high together with ack_o
//     stall_o  pipeline hold = req_i & ~ack_o
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        commit;
  logic        legal;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH];

  // Legality is judged on the latched address only; inputs may wander in WAIT.
  assign legal = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < 32'(DEPTH));
  assign idx   = addr_q[IDX_W+1:2];

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: if (req_i) state_nxt = WAIT;
      WAIT: if (cnt == 4'd0) begin
        state_nxt = DONE;
        commit    = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        cnt     <= 4'(LATENCY);
      end
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      // Access takes effect on the WAIT->DONE edge. An illegal access of
      // either kind zeroes rdata_o; a legal write leaves it untouched.
      if (commit) begin
        if (legal) begin
          if (we_q) mem[idx] <= wdata_q;
          else      rdata_o  <= mem[idx];
          err_q <= 1'b0;
        end else begin
          rdata_o <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign ack_o   = (state == DONE);
  assign err_o   = ack_o & err_q;
  assign stall_o = req_i & ~ack_o;

endmodule
